tiny_fir_sequencer: RTL

TINY_FIR_SEQUENCER -- requirements
Module: tiny_fir_sequencer

---
 rtl/tiny_fir_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/tiny_fir_sequencer.sv
// tiny_fir_sequencer: single-MAC FIR that loads its taps over a stream, then filters one sample per pass.
// Optional build macro TINY_FIR_SAT_EN saturates dout to the signed data range instead of wrapping.

module tiny_fir_sequencer #(
  parameter int G_NUM_TAPS   = 16,
  parameter int G_DATA_WIDTH = 16,
  parameter int G_TAP_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [G_TAP_WIDTH-1:0]  tap_din,
  input  logic                    tap_din_valid,
  output logic                    tap_din_ready,
  output logic                    tap_din_done,
  input  logic [G_DATA_WIDTH-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [G_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [2:0]              o_dbg_state
);

  localparam int C_AW   = $clog2(G_NUM_TAPS);
  localparam int C_PW   = G_DATA_WIDTH + G_TAP_WIDTH;
  localparam int C_ACCW = C_PW + C_AW;
  localparam int C_KW   = C_AW + 2;

  typedef enum logic [2:0] {
    SM_INIT         = 3'd0,
    SM_PROGRAM_TAPS = 3'd1,
    SM_GET_INPUT    = 3'd2,
    SM_CALC         = 3'd3,
    SM_SEND_OUTPUT  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]                     r_rst_sync;
  logic                           w_rst_n;

  logic [G_TAP_WIDTH-1:0]         r_tap_mem  [G_NUM_TAPS];
  logic [G_DATA_WIDTH-1:0]        r_hist_mem [G_NUM_TAPS];
  logic [G_TAP_WIDTH-1:0]         r_tap_rd;
  logic [G_DATA_WIDTH-1:0]        r_hist_rd;

  logic [C_AW-1:0]                r_init_cnt;
  logic [C_AW-1:0]                r_tap_cnt;
  logic [C_AW-1:0]                r_wp;
  logic [C_AW-1:0]                r_base;
  logic [C_KW-1:0]                r_k;

  logic                           r_rd_vld;
  logic                           r_prod_vld;
  logic [C_PW-1:0]                r_prod;
  logic signed [C_ACCW-1:0]       r_acc;

  logic [G_DATA_WIDTH-1:0]        r_dout;
  logic                           r_dout_valid;
  logic                           r_din_ready;
  logic                           r_tap_din_ready;
  logic                           r_tap_din_done;

  logic                           w_tap_hs;
  logic                           w_din_hs;
  logic                           w_dout_hs;
  logic                           w_init_last;
  logic                           w_tap_last;
  logic                           w_calc_last;
  logic                           w_issue;
  logic [C_AW-1:0]                w_tap_raddr;
  logic [C_AW-1:0]                w_hist_raddr;
  logic                           w_hist_we;
  logic [C_AW-1:0]                w_hist_waddr;
  logic [G_DATA_WIDTH-1:0]        w_hist_wdata;
  logic [C_PW-1:0]                w_hist_ext;
  logic [C_PW-1:0]                w_tap_ext;
  logic [C_PW-1:0]                w_prod;
  logic signed [C_ACCW-1:0]       w_acc_sum;
  logic [G_DATA_WIDTH-1:0]        w_dout_next;

  // Reset asserts immediately but releases two clock edges later, aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Valid/ready: a transfer happens on a rising edge where both are high; every
  // ready/valid output here is a flop decoded from the next state, never from its partner.
  assign w_tap_hs  = enable && tap_din_valid && r_tap_din_ready;
  assign w_din_hs  = enable && din_valid && r_din_ready;
  assign w_dout_hs = enable && r_dout_valid && dout_ready;

  assign w_init_last = (r_init_cnt == C_AW'(G_NUM_TAPS - 1));
  assign w_tap_last  = (r_tap_cnt == C_AW'(G_NUM_TAPS - 1));
  assign w_calc_last = (r_k == C_KW'(G_NUM_TAPS + 1));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= SM_INIT;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = SM_INIT;
    end else begin
      case (r_state)
        SM_INIT:         if (w_init_last)             w_state_next = SM_PROGRAM_TAPS;
        SM_PROGRAM_TAPS: if (w_tap_hs && w_tap_last)  w_state_next = SM_GET_INPUT;
        SM_GET_INPUT:    if (w_din_hs)                w_state_next = SM_CALC;
        SM_CALC:         if (w_calc_last)             w_state_next = SM_SEND_OUTPUT;
        SM_SEND_OUTPUT:  if (w_dout_hs)               w_state_next = SM_GET_INPUT;
        default:                                      w_state_next = SM_INIT;
      endcase
    end
  end

  // Calc runs N issue cycles plus two to drain the read and multiply stages.
  assign w_issue      = enable && (r_state == SM_CALC) && (r_k < C_KW'(G_NUM_TAPS));
  assign w_tap_raddr  = r_k[C_AW-1:0];
  assign w_hist_raddr = r_base - r_k[C_AW-1:0];

  assign w_hist_we    = enable && ((r_state == SM_INIT) || w_din_hs);
  assign w_hist_waddr = (r_state == SM_INIT) ? r_init_cnt : r_wp;
  assign w_hist_wdata = (r_state == SM_INIT) ? '0 : din;

  always_ff @(posedge clk) begin
    if (w_tap_hs)  r_tap_mem[r_tap_cnt]     <= tap_din;
    if (w_hist_we) r_hist_mem[w_hist_waddr] <= w_hist_wdata;
    r_tap_rd  <= r_tap_mem[w_tap_raddr];
    r_hist_rd <= r_hist_mem[w_hist_raddr];
  end

  assign w_hist_ext = {{G_TAP_WIDTH{r_hist_rd[G_DATA_WIDTH-1]}}, r_hist_rd};
  assign w_tap_ext  = {{G_DATA_WIDTH{r_tap_rd[G_TAP_WIDTH-1]}}, r_tap_rd};
  assign w_prod     = w_hist_ext * w_tap_ext;
  assign w_acc_sum  = r_prod_vld ? (r_acc + {{C_AW{r_prod[C_PW-1]}}, r_prod}) : r_acc;

`ifdef TINY_FIR_SAT_EN
  logic [C_ACCW-C_PW+1:0] w_acc_hi;
  always_comb begin
    w_acc_hi    = w_acc_sum[C_ACCW-1:C_PW-2];
    w_dout_next = w_acc_sum[C_PW-2:G_TAP_WIDTH-1];
    // Bits above the output slice must all match its sign bit, otherwise clamp.
    if (!((&w_acc_hi) || !(|w_acc_hi))) begin
      w_dout_next = w_acc_hi[C_ACCW-C_PW+1] ? {1'b1, {(G_DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(G_DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    w_dout_next = w_acc_sum[C_PW-2:G_TAP_WIDTH-1];
  end
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_din_ready     <= 1'b0;
      r_tap_din_ready <= 1'b0;
      r_tap_din_done  <= 1'b0;
      r_dout_valid    <= 1'b0;
      r_dout          <= '0;
      r_init_cnt      <= '0;
      r_tap_cnt       <= '0;
      r_wp            <= '0;
      r_base          <= '0;
      r_k             <= '0;
      r_acc           <= '0;
      r_rd_vld        <= 1'b0;
      r_prod_vld      <= 1'b0;
      r_prod          <= '0;
    end else begin
      r_din_ready     <= (w_state_next == SM_GET_INPUT);
      r_tap_din_ready <= (w_state_next == SM_PROGRAM_TAPS);
      r_tap_din_done  <= (w_state_next == SM_GET_INPUT) || (w_state_next == SM_CALC) ||
                         (w_state_next == SM_SEND_OUTPUT);
      r_dout_valid    <= (w_state_next == SM_SEND_OUTPUT);
      r_rd_vld        <= w_issue;
      r_prod_vld      <= r_rd_vld && enable;
      r_prod          <= w_prod;
      if (!enable) begin
        r_init_cnt <= '0;
        r_tap_cnt  <= '0;
        r_wp       <= '0;
        r_base     <= '0;
        r_k        <= '0;
        r_acc      <= '0;
      end else begin
        case (r_state)
          SM_INIT: begin
            r_init_cnt <= r_init_cnt + C_AW'(1);
            if (w_init_last) begin
              r_wp      <= '0;
              r_tap_cnt <= '0;
            end
          end
          SM_PROGRAM_TAPS: begin
            if (w_tap_hs) r_tap_cnt <= r_tap_cnt + C_AW'(1);
          end
          SM_GET_INPUT: begin
            if (w_din_hs) begin
              r_base <= r_wp;
              r_wp   <= r_wp + C_AW'(1);
              r_acc  <= '0;
              r_k    <= '0;
            end
          end
          SM_CALC: begin
            r_acc <= w_acc_sum;
            if (w_calc_last) r_dout <= w_dout_next;
            else             r_k    <= r_k + C_KW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign din_ready     = r_din_ready;
  assign tap_din_ready = r_tap_din_ready;
  assign tap_din_done  = r_tap_din_done;
  assign dout_valid    = r_dout_valid;
  assign dout          = r_dout;
  assign o_dbg_state   = r_state;

endmodule
